// File: rtl/mii_rx_nibble_packer_if.sv
// Nibble-in / byte-strobe-out bundle between the MII receive front end and the MII data buffer.
interface mii_rx_nibble_packer_if #(
  parameter int FLW_P = 11
);
  logic             RxNibEn;
  logic             RxDv;
  logic             RxEr;
  logic [3:0]       RxD;
  logic             OutMiiBusy;
  logic             OutMiiClkEn;
  logic             OutMiiDataEn;
  logic [7:0]       OutMiiData;
  logic             FrameDone;
  logic             FrameErr;
  logic             OverflowErr;
  logic [FLW_P-1:0] FrameLen;

  modport master (
    output RxNibEn, RxDv, RxEr, RxD, OutMiiBusy,
    input  OutMiiClkEn, OutMiiDataEn, OutMiiData, FrameDone, FrameErr, OverflowErr, FrameLen
  );

  modport slave (
    input  RxNibEn, RxDv, RxEr, RxD, OutMiiBusy,
    output OutMiiClkEn, OutMiiDataEn, OutMiiData, FrameDone, FrameErr, OverflowErr, FrameLen
  );
endinterface

// File: rtl/mii_rx_nibble_packer.sv
// Packs MII receive nibbles into a free-running byte-strobe stream, strips preamble/SFD,
// and flags framing, preamble, dribble, length and overflow errors.
module mii_rx_nibble_packer #(
  parameter int  TCo_C          = 1,
  parameter int  MinPreNib_C    = 7,
  parameter int  MaxFrameByte_C = 1522,
  localparam int FLW_C          = $clog2(MaxFrameByte_C + 1)
) (
  input  logic InClock,
  input  logic Reset_N,
  mii_rx_nibble_packer_if.slave bus
);
  localparam int               PCW_C     = $clog2(MinPreNib_C + 1);
  localparam logic [FLW_C-1:0] MaxLen_C  = FLW_C'(MaxFrameByte_C);
  localparam logic [PCW_C-1:0] MinPre_C  = PCW_C'(MinPreNib_C);

  // TCo_C only models clock-to-out in behavioural sims; it has no effect on this logic.
  if (TCo_C < 0) begin : g_tco_invalid
  end

  typedef enum logic [1:0] {IDLE, PRE, DATA, DRAIN} state_e;

  state_e           state_q, state_d;
  logic             nibph_q, nibph_d;
  logic [PCW_C-1:0] precnt_q, precnt_d;
  logic [3:0]       low_q, low_d;
  logic             clken_q, clken_d;
  logic             daten_q, daten_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic [FLW_C-1:0] flen_q, flen_d;

  logic nib, is5, sfd_ok, len_full;
  assign nib      = bus.RxNibEn;
  assign is5      = (bus.RxD == 4'h5);
  assign sfd_ok   = (bus.RxD == 4'hD) && (precnt_q >= MinPre_C);
  assign len_full = (flen_q == MaxLen_C);

  always_ff @(posedge InClock or negedge Reset_N) begin
    if (!Reset_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (nib) begin
      case (state_q)
        IDLE:  if (bus.RxDv) state_d = is5 ? PRE : DRAIN;
        PRE: begin
          if (!bus.RxDv)      state_d = IDLE;
          else if (bus.RxEr)  state_d = DRAIN;
          else if (!is5)      state_d = sfd_ok ? DATA : DRAIN;
        end
        DATA: begin
          if (!bus.RxDv)      state_d = IDLE;
          else if (bus.RxEr)  state_d = DRAIN;
          else if (nibph_q && (len_full || bus.OutMiiBusy)) state_d = DRAIN;
        end
        DRAIN: if (!bus.RxDv) state_d = IDLE;
        default:              state_d = IDLE;
      endcase
    end
  end

  // Busy is sampled with the completing nibble so OverflowErr lines up with the byte strobe.
  always_comb begin
    nibph_d  = nibph_q;
    precnt_d = precnt_q;
    low_d    = low_q;
    clken_d  = 1'b0;
    daten_d  = daten_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ovf_d    = 1'b0;
    flen_d   = flen_q;
    if (nib) begin
      nibph_d = ~nibph_q;
      clken_d = nibph_q;
      if (nibph_q) begin
        daten_d = 1'b0;
        data_d  = 8'h00;
      end
      case (state_q)
        IDLE: begin
          if (bus.RxDv) begin
            if (is5) precnt_d = PCW_C'(1);
            else     err_d    = 1'b1;
          end
        end
        PRE: begin
          if (bus.RxDv) begin
            if (bus.RxEr) err_d = 1'b1;
            else if (is5) begin
              if (precnt_q < MinPre_C) precnt_d = precnt_q + PCW_C'(1);
            end else if (sfd_ok) begin
              nibph_d = 1'b0;
              flen_d  = '0;
            end else err_d = 1'b1;
          end
        end
        DATA: begin
          if (!bus.RxDv) begin
            done_d = 1'b1;
            err_d  = nibph_q;
          end else if (bus.RxEr) err_d = 1'b1;
          else if (!nibph_q)     low_d = bus.RxD;
          else if (len_full)     err_d = 1'b1;
          else begin
            daten_d = 1'b1;
            data_d  = {bus.RxD, low_q};
            flen_d  = flen_q + FLW_C'(1);
            if (bus.OutMiiBusy) begin
              ovf_d = 1'b1;
              err_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge InClock or negedge Reset_N) begin
    if (!Reset_N) begin
      nibph_q  <= 1'b0;
      precnt_q <= '0;
      low_q    <= '0;
      clken_q  <= 1'b0;
      daten_q  <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      flen_q   <= '0;
    end else begin
      nibph_q  <= nibph_d;
      precnt_q <= precnt_d;
      low_q    <= low_d;
      clken_q  <= clken_d;
      daten_q  <= daten_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      flen_q   <= flen_d;
    end
  end

  assign bus.OutMiiClkEn  = clken_q;
  assign bus.OutMiiDataEn = daten_q;
  assign bus.OutMiiData   = data_q;
  assign bus.FrameDone    = done_q;
  assign bus.FrameErr     = err_q;
  assign bus.OverflowErr  = ovf_q;
  assign bus.FrameLen     = flen_q;
endmodule

// File: tb/tb_mii_rx_nibble_packer.sv
// Directed frame vectors against two packer instances (default and MaxFrameByte_C=4).
module tb_mii_rx_nibble_packer;
  logic InClock = 1'b0;
  logic Reset_N = 1'b0;
  logic rx_nib_en = 1'b0, rx_dv = 1'b0, rx_er = 1'b0, busy = 1'b0;
  logic [3:0] rx_d = 4'h0;

  always #5 InClock = ~InClock;

  mii_rx_nibble_packer_if #(.FLW_P(11)) bus_a ();
  mii_rx_nibble_packer_if #(.FLW_P(3))  bus_b ();

  assign bus_a.RxNibEn = rx_nib_en;  assign bus_b.RxNibEn = rx_nib_en;
  assign bus_a.RxDv    = rx_dv;      assign bus_b.RxDv    = rx_dv;
  assign bus_a.RxEr    = rx_er;      assign bus_b.RxEr    = rx_er;
  assign bus_a.RxD     = rx_d;       assign bus_b.RxD     = rx_d;
  assign bus_a.OutMiiBusy = busy;    assign bus_b.OutMiiBusy = busy;

  mii_rx_nibble_packer dut_a (.InClock(InClock), .Reset_N(Reset_N), .bus(bus_a.slave));
  mii_rx_nibble_packer #(.MaxFrameByte_C(4)) dut_b (.InClock(InClock), .Reset_N(Reset_N), .bus(bus_b.slave));

  logic sel = 1'b0;
  logic m_clk, m_den, m_done, m_err, m_ovf;
  logic [7:0]  m_data;
  logic [10:0] m_flen;
  always_comb begin
    m_clk  = sel ? bus_b.OutMiiClkEn  : bus_a.OutMiiClkEn;
    m_den  = sel ? bus_b.OutMiiDataEn : bus_a.OutMiiDataEn;
    m_data = sel ? bus_b.OutMiiData   : bus_a.OutMiiData;
    m_done = sel ? bus_b.FrameDone    : bus_a.FrameDone;
    m_err  = sel ? bus_b.FrameErr     : bus_a.FrameErr;
    m_ovf  = sel ? bus_b.OverflowErr  : bus_a.OverflowErr;
    m_flen = sel ? {8'b0, bus_b.FrameLen} : bus_a.FrameLen;
  end

  logic mon_clr = 1'b1;
  int slots_n, got_n, done_n, err_n, ovf_n, both_n, idle_bad_n;
  logic [7:0] got_b [0:15];
  always @(negedge InClock) begin
    if (mon_clr) begin
      slots_n <= 0; got_n <= 0; done_n <= 0; err_n <= 0;
      ovf_n <= 0; both_n <= 0; idle_bad_n <= 0;
    end else begin
      if (m_clk) begin
        slots_n <= slots_n + 1;
        if (m_den) begin
          if (got_n < 16) got_b[got_n[3:0]] <= m_data;
          got_n <= got_n + 1;
        end else if (m_data != 8'h00) idle_bad_n <= idle_bad_n + 1;
      end
      if (m_done) done_n <= done_n + 1;
      if (m_err)  err_n  <= err_n + 1;
      if (m_ovf)  ovf_n  <= ovf_n + 1;
      if (m_done && m_err) both_n <= both_n + 1;
    end
  end

  int checks = 0, failures = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int gap_g = 1;
  task automatic nib(input logic dv, input logic er, input logic [3:0] d);
    rx_nib_en = 1'b1; rx_dv = dv; rx_er = er; rx_d = d;
    @(negedge InClock);
    rx_nib_en = 1'b0;
    repeat (gap_g) @(negedge InClock);
  endtask

  task automatic do_reset();
    Reset_N = 1'b0; rx_nib_en = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; busy = 1'b0;
    mon_clr = 1'b1;
    repeat (2) @(negedge InClock);
    Reset_N = 1'b1; mon_clr = 1'b0;
    @(negedge InClock);
  endtask

  typedef struct {
    logic        sel;
    int          gap;
    int          npre;
    logic [3:0]  sfd;
    int          ndat;
    logic [47:0] dat;      // nibble j at [4j+:4]
    int          er_idx;
    int          busy_idx;
    int          nbytes;
    logic [31:0] bytes;    // byte k at [8k+:8]
    int          slots;
    int          done_n;
    int          err_n;
    int          ovf_n;
    int          both_n;
    int          flen;
  } vec_t;

  vec_t tbl [10];

  task automatic run_vec(input int idx, input vec_t v, input bit rst);
    sel = v.sel; gap_g = v.gap;
    if (rst) do_reset();
    else begin
      mon_clr = 1'b1;
      repeat (2) @(negedge InClock);
      mon_clr = 1'b0;
    end
    for (int j = 0; j < v.npre; j++) nib(1'b1, 1'b0, 4'h5);
    nib(1'b1, 1'b0, v.sfd);
    for (int j = 0; j < v.ndat; j++) begin
      busy = (j == v.busy_idx);
      nib(1'b1, (j == v.er_idx), v.dat[4*j +: 4]);
    end
    busy = 1'b0;
    repeat (4) nib(1'b0, 1'b0, 4'h0);
    repeat (4) @(negedge InClock);
    check($sformatf("v%0d slots", idx), slots_n, v.slots);
    check($sformatf("v%0d nbytes", idx), got_n, v.nbytes);
    for (int k = 0; k < v.nbytes && k < 4; k++)
      check($sformatf("v%0d byte%0d", idx, k), got_b[k], v.bytes[8*k +: 8]);
    check($sformatf("v%0d done", idx), done_n, v.done_n);
    check($sformatf("v%0d err", idx), err_n, v.err_n);
    check($sformatf("v%0d ovf", idx), ovf_n, v.ovf_n);
    check($sformatf("v%0d done_err_same", idx), both_n, v.both_n);
    check($sformatf("v%0d idle_data_zero", idx), idle_bad_n, 0);
    check($sformatf("v%0d flen", idx), m_flen, v.flen);
  endtask

  initial begin
    //          sel gap pre sfd   nd dat              er  bsy nb bytes           sl dn er ov bo fl
    tbl[0] = '{1'b0, 1, 7, 4'hD, 4,  48'h3412,        -1, -1, 2, 32'h3412,       8, 1, 0, 0, 0, 2};
    tbl[1] = '{1'b0, 1, 3, 4'hD, 4,  48'h3412,        -1, -1, 0, 32'h0,          6, 0, 1, 0, 0, 0};
    tbl[2] = '{1'b0, 2, 7, 4'hD, 5,  48'hF3412,       -1, -1, 2, 32'h3412,       8, 1, 1, 0, 1, 2};
    tbl[3] = '{1'b0, 1, 7, 4'hD, 8,  48'h87653412,     4, -1, 2, 32'h3412,      10, 0, 1, 0, 0, 2};
    tbl[4] = '{1'b0, 1, 7, 4'hD, 6,  48'h563412,      -1,  3, 2, 32'h3412,       9, 0, 1, 1, 0, 2};
    tbl[5] = '{1'b0, 0, 7, 4'hD, 6,  48'hCAD50F,      -1, -1, 3, 32'hCAD50F,     9, 1, 0, 0, 0, 3};
    tbl[6] = '{1'b0, 0, 10, 4'hD, 4, 48'h3412,        -1, -1, 2, 32'h3412,       9, 1, 0, 0, 0, 2};
    tbl[7] = '{1'b0, 1, 0, 4'h3, 2,  48'h12,          -1, -1, 0, 32'h0,          3, 0, 1, 0, 0, 0};
    tbl[8] = '{1'b1, 1, 7, 4'hD, 10, 48'h9A78563412,  -1, -1, 4, 32'h78563412,  11, 0, 1, 0, 0, 4};
    tbl[9] = '{1'b1, 0, 7, 4'hD, 8,  48'h78563412,    -1, -1, 4, 32'h78563412,  10, 1, 0, 0, 0, 4};

    @(negedge InClock);
    check("reset_outputs_a", {bus_a.OutMiiClkEn, bus_a.OutMiiDataEn, bus_a.OutMiiData, bus_a.FrameDone,
                              bus_a.FrameErr, bus_a.OverflowErr, bus_a.FrameLen}, '0);
    check("reset_outputs_b", {bus_b.OutMiiClkEn, bus_b.OutMiiDataEn, bus_b.OutMiiData, bus_b.FrameDone,
                              bus_b.FrameErr, bus_b.OverflowErr, bus_b.FrameLen}, '0);

    for (int i = 0; i < 10; i++) run_vec(i, tbl[i], 1'b1);

    // Reset asserted mid-DATA: outputs clear at once and the frame vanishes silently.
    sel = 1'b0; gap_g = 1;
    do_reset();
    for (int j = 0; j < 7; j++) nib(1'b1, 1'b0, 4'h5);
    nib(1'b1, 1'b0, 4'hD);
    nib(1'b1, 1'b0, 4'h2);
    nib(1'b1, 1'b0, 4'h1);
    nib(1'b1, 1'b0, 4'h4);
    check("midreset_pre_flen", m_flen, 11'd1);
    check("midreset_pre_data", m_data, 8'h12);
    Reset_N = 1'b0;
    #1;
    check("midreset_outputs", {m_clk, m_den, m_data, m_done, m_err, m_ovf, m_flen}, '0);
    repeat (2) @(negedge InClock);
    Reset_N = 1'b1;
    repeat (4) nib(1'b0, 1'b0, 4'h0);
    repeat (2) @(negedge InClock);
    check("midreset_no_done", done_n, 0);
    check("midreset_no_err", err_n, 0);
    check("midreset_bytes", got_n, 1);

    // Recovery: good frame straight after, no intervening reset.
    run_vec(10, tbl[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
